// File: rtl/axis_frame_tx.sv
// AXI-Stream framed transmitter: sample FIFO feeding a registered output
// stage that adds tlast, tid and tdest framing.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_en,
  output logic                          wr_full,
  output logic                          wr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic [LEN_W-1:0]              cfg_frame_len,
  input  logic [3:0]                    cfg_tdest,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_tlast,
  output logic [7:0]                    m_tid,
  output logic [3:0]                    m_tdest,
  output logic [DATA_WIDTH/8-1:0]       m_tstrb,
  output logic [DATA_WIDTH/8-1:0]       m_tkeep
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW:0]           level_d;
  logic                  fifo_empty;
  logic                  push, load, hs;
  logic [LEN_W-1:0]      beat_q, len_q;
  logic [LEN_W-1:0]      cfg_len, len_cur;
  logic                  beat_last;
  logic [7:0]            frame_id, frame_id_nx;

  assign m_tstrb       = '1;
  assign m_tkeep       = '1;
  assign m_axis_tvalid = (state_q == S_FULL);
  assign hs            = m_axis_tvalid & m_axis_tready;
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign push          = wr_en & ~wr_full;
  assign level_d       = fifo_level + LW'(push) - LW'(load);

  // Length and tdest are sampled only when beat 0 is loaded
  assign cfg_len   = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
  assign len_cur   = (beat_q == '0) ? cfg_len : len_q;
  assign beat_last = (beat_q == len_cur - LEN_W'(1));

  assign frame_id_nx = (hs & m_tlast) ? frame_id + 8'd1 : frame_id;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (hs) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      wr_full     <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + LW'(push);
      rd_ptr      <= rd_ptr + LW'(load);
      fifo_level  <= level_d;
      wr_full     <= (level_d == LW'(FIFO_DEPTH));
      wr_overflow <= wr_en & wr_full;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tdata <= '0;
      m_tlast      <= 1'b0;
      m_tid        <= '0;
      m_tdest      <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      frame_id     <= '0;
    end else begin
      frame_id <= frame_id_nx;
      if (load) begin
        m_axis_tdata <= mem[rd_ptr[AW-1:0]];
        m_tlast      <= beat_last;
        m_tid        <= frame_id_nx;
        beat_q       <= beat_last ? '0 : beat_q + LEN_W'(1);
        if (beat_q == '0) begin
          len_q   <= cfg_len;
          m_tdest <= cfg_tdest;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Randomized bench for axis_frame_tx against a queue-based
// transaction model of the framed stream.
module tb_axis_frame_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_full;
  logic          wr_overflow;
  logic [4:0]    fifo_level;
  logic [7:0]    cfg_frame_len;
  logic [3:0]    cfg_tdest;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_tlast;
  logic [7:0]    m_tid;
  logic [3:0]    m_tdest;
  logic [1:0]    m_tstrb;
  logic [1:0]    m_tkeep;

  always #5 clk = ~clk;

  axis_frame_tx #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .LEN_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_full(wr_full),
    .wr_overflow(wr_overflow),
    .fifo_level(fifo_level),
    .cfg_frame_len(cfg_frame_len),
    .cfg_tdest(cfg_tdest),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_tlast(m_tlast),
    .m_tid(m_tid),
    .m_tdest(m_tdest),
    .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep)
  );

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  bit            ov;
  logic [DW-1:0] od;
  bit            olast;
  logic [7:0]    otid;
  logic [3:0]    odest;
  int            bi;
  int            flen;
  logic [7:0]    ftid;
  bit            e_ovf;
  int            n_hs;
  int            n_ovf;
  int            last_hs_tid;
  bit            wrap_seen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    sb.delete();
    ov = 0; od = '0; olast = 0; otid = '0; odest = '0;
    bi = 0; flen = 1; ftid = '0; e_ovf = 0;
  endtask

  task automatic drive(input bit we, input logic [DW-1:0] d,
                       input bit rdy);
    wr_en         = we;
    wr_data       = d;
    m_axis_tready = rdy;
  endtask

  task automatic compare();
    check("tvalid", m_axis_tvalid, ov);
    check("level", fifo_level, fq.size());
    check("full", wr_full, fq.size() == DEPTH);
    check("ovf", wr_overflow, e_ovf);
    check("strb_keep", {m_tstrb, m_tkeep}, 4'hf);
    if (ov) begin
      check("tdata", m_axis_tdata, od);
      check("tlast", m_tlast, olast);
      check("tid", m_tid, otid);
      check("tdest", m_tdest, odest);
    end
  endtask

  // One clock: score the DUT handshake, advance the model, compare.
  task automatic step();
    bit full, hs, ld;
    int cl;
    if (m_axis_tvalid && m_axis_tready) begin
      check("hs_avail", sb.size() > 0, 1);
      if (sb.size() > 0) check("hs_order", m_axis_tdata, sb.pop_front());
      n_hs++;
      if (m_tid == 8'd0 && last_hs_tid == 255) wrap_seen = 1;
      last_hs_tid = m_tid;
    end
    full  = (fq.size() == DEPTH);
    hs    = ov && m_axis_tready;
    e_ovf = wr_en && full;
    if (e_ovf) n_ovf++;
    if (hs && olast) ftid = ftid + 8'd1;
    ld = (fq.size() > 0) && (!ov || hs);
    if (ld) begin
      if (bi == 0) begin
        cl    = cfg_frame_len;
        flen  = (cl == 0) ? 1 : cl;
        odest = cfg_tdest;
      end
      od    = fq.pop_front();
      olast = (bi == flen - 1);
      bi    = olast ? 0 : bi + 1;
      otid  = ftid;
      ov    = 1;
    end else if (hs) begin
      ov = 0;
    end
    if (wr_en && !full) begin
      fq.push_back(wr_data);
      sb.push_back(wr_data);
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    drive(0, '0, 0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    last_hs_tid = -1;
  endtask

  initial begin
    int h0;
    int o0;
    bit changed;
    rst           = 1'b0;
    cfg_frame_len = 8'd4;
    cfg_tdest     = 4'd3;
    n_hs          = 0;
    n_ovf         = 0;
    wrap_seen     = 0;
    last_hs_tid   = -1;
    do_reset();
    compare();
    check("rst_tid", m_tid, 0);
    check("rst_tlast", m_tlast, 0);

    // eight samples, frames of four
    for (int i = 1; i <= 8; i++) begin
      drive(1, DW'(i), 1);
      step();
    end
    drive(0, '0, 1);
    repeat (4) step();
    check("t1_beats", n_hs, 8);

    // backpressure on a six-beat stream
    cfg_frame_len = 8'd3;
    h0 = n_hs;
    for (int i = 0; i < 24; i++) begin
      drive(i < 6, DW'(i + 1), (i % 3) == 0);
      step();
    end
    check("bp_beats", n_hs - h0, 6);

    // fill past capacity with the sink stalled
    h0 = n_hs;
    o0 = n_ovf;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1, DW'(16'h100 + i), 0);
      step();
    end
    drive(0, '0, 0);
    step();
    check("fill_level", fifo_level, 16);
    check("fill_full", wr_full, 1);
    check("fill_ovf_cnt", n_ovf - o0, 1);
    drive(0, '0, 1);
    repeat (DEPTH + 4) step();
    check("drain_beats", n_hs - h0, DEPTH + 1);

    // zero length: every beat is a frame, tid must wrap
    do_reset();
    cfg_frame_len = 8'd0;
    for (int i = 0; i < 257; i++) begin
      drive(1, DW'($urandom), 1);
      step();
    end
    drive(0, '0, 1);
    repeat (4) step();
    check("tid_wrap", wrap_seen, 1);

    // config change at beat 1 applies to the next frame only
    cfg_frame_len = 8'd4;
    cfg_tdest     = 4'd3;
    changed       = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i < 6, DW'(16'h200 + i), 1);
      step();
      if (!changed && bi == 1 && ov) begin
        check("cc_dest_old", m_tdest, 3);
        cfg_frame_len = 8'd2;
        cfg_tdest     = 4'd9;
        changed       = 1;
      end
    end
    check("cc_changed", changed, 1);
    check("cc_bi", bi, 0);

    // randomized traffic with random framing config
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        cfg_frame_len = 8'($urandom_range(0, 5));
        cfg_tdest     = 4'($urandom);
      end
      drive($urandom_range(0, 3) != 0, DW'($urandom),
            $urandom_range(0, 2) != 0);
      step();
    end
    drive(0, '0, 1);
    repeat (DEPTH + 4) step();
    check("rnd_drained", sb.size(), 0);

    // reset in the middle of a frame
    do_reset();
    cfg_frame_len = 8'd4;
    cfg_tdest     = 4'd5;
    for (int i = 0; i < 8; i++) begin
      drive(1, DW'(16'h300 + i), 0);
      step();
    end
    drive(0, '0, 1);
    for (int i = 0; i < 20; i++) begin
      if (ov && bi == 3 && otid == 8'd1) break;
      step();
    end
    check("mid_tid_pre", m_tid, 1);
    check("mid_valid_pre", m_axis_tvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tlast", m_tlast, 0);
    check("arst_tid", m_tid, 0);
    check("arst_level", fifo_level, 0);
    model_reset();
    drive(0, '0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_hs_tid = -1;
    drive(1, 16'h0abc, 1);
    step();
    drive(0, '0, 1);
    step();
    check("post_rst_valid", m_axis_tvalid, 1);
    check("post_rst_tid", m_tid, 0);
    check("post_rst_tlast", m_tlast, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
